// File: rtl/signed_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : signed_seq_multiplier
// Description : Sequential signed multiplier. It multiplies the magnitudes of
//               two WIDTH-bit two's-complement operands by shift-and-add, one
//               multiplier bit per cycle, then applies the sign. Both sides
//               use a valid/ready handshake and the latency is fixed.
// Ports       : clk        - single clock, rising edge
//               rst_n      - synchronous, active-low reset
//               in_valid   - operands a/b valid this cycle
//               in_ready   - block can accept operands (IDLE only)
//               a, b       - WIDTH-bit signed multiplicand / multiplier
//               out_valid  - product valid, held until accepted
//               out_ready  - consumer accepts the product
//               product    - 2*WIDTH-bit signed product, registered
//               busy       - operation in progress or waiting for the consumer
// Revision    : 1.0 - initial release
// ============================================================================
module signed_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_PW-1:0]    c_ONE_P    = {{(c_PW-1){1'b0}}, 1'b1};

    // State encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [c_PW-1:0]    acc_q,     acc_d;
    logic [c_CNT_W-1:0] cnt_q,     cnt_d;
    logic               neg_q,     neg_d;
    logic [c_PW-1:0]    product_q, product_d;

    // ------------------------------------------------------------------------
    // Operand magnitudes. The most negative value maps onto itself, which is
    // still correct once the result is read as an unsigned WIDTH-bit number.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_a_mag = a[WIDTH-1] ? (~a + c_ONE_W) : a;
    assign w_b_mag = b[WIDTH-1] ? (~b + c_ONE_W) : b;

    // ------------------------------------------------------------------------
    // Partial-sum adder: acc + (mcand << cnt) when the current multiplier bit
    // is set. The carry out of the top bit is never produced because the
    // magnitude product always fits in 2*WIDTH bits.
    // ------------------------------------------------------------------------
    logic [c_PW-1:0] w_shifted;
    logic [c_PW-1:0] w_addend;
    logic [c_PW-1:0] w_sum;
    logic [c_PW-1:0] w_carry;

    assign w_shifted  = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    assign w_addend   = mplier_q[0] ? w_shifted : '0;
    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < c_PW; i++) begin : g_add_bit
        assign w_sum[i] = acc_q[i] ^ w_addend[i] ^ w_carry[i];
        if (i < c_PW - 1) begin : g_carry
            assign w_carry[i+1] = (acc_q[i] & w_addend[i])
                                | (acc_q[i] & w_carry[i])
                                | (w_addend[i] & w_carry[i]);
        end
    end

    // Signed result of the final iteration; a zero magnitude stays zero
    // because ~0 + 1 wraps back to 0.
    logic [c_PW-1:0] w_signed_result;

    assign w_signed_result = neg_q ? (~w_sum + c_ONE_P) : w_sum;

    // ------------------------------------------------------------------------
    // Process 1: state register (and all datapath flops)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= c_ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    mcand_d  = w_a_mag;
                    mplier_d = w_b_mag;
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = c_ST_CALC;
                end
            end

            c_ST_CALC: begin
                // One multiplier bit per cycle; always WIDTH iterations so the
                // latency never depends on operand values.
                acc_d    = w_sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_LAST_CNT) begin
                    product_d = w_signed_result;
                    cnt_d     = '0;
                    state_d   = c_ST_DONE;
                end
            end

            c_ST_DONE: begin
                // Product is held until the consumer takes it; it also keeps
                // its value after the handshake.
                if (out_ready) begin
                    state_d = c_ST_IDLE;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs, decoded from the registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                in_ready = 1'b1;
            end
            c_ST_CALC: begin
                busy = 1'b1;
            end
            c_ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_seq_multiplier
// Description : Self-checking bench for signed_seq_multiplier. Expected
//               products come from plain signed arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_seq_multiplier;

    localparam int WIDTH   = 8;
    localparam int c_LAT   = WIDTH;
    localparam int c_BOUND = 64;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    int checks;
    int errors;

    signed_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed product, truncated to the product width.
    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        int p;
        p = $signed(x) * $signed(y);
        return p[2*WIDTH-1:0];
    endfunction

    // Advance one clock; drive and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one cycle (accept happens on this edge if ready).
    task automatic drive_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = $urandom();
        b        = $urandom();
    endtask

    // Wait (bounded) for out_valid; reports cycles after accept and timeout.
    task automatic wait_valid(output int cycles, output bit timed_out);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < c_BOUND) begin
            tick();
            cycles++;
        end
        timed_out = (out_valid !== 1'b1);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int  lat;
        bit  to;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end

        // Reset while parked in DONE with a nonzero product
        out_ready = 1'b0;
        drive_op(8'd9, 8'd9);
        wait_valid(lat, to);
        checks++; if (to) begin errors++; $display("FAIL reset_pre_op_timeout: got no out_valid expected out_valid"); end
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL reset_from_done_ctrl: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy); end
        checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_from_done_product: got %h expected 0000", product); end
        out_ready = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_basic();
        int lat;
        bit to;
        out_ready = 1'b1;
        drive_op(8'd5, 8'd3);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL basic_calc_ctrl: got busy=%b ir=%b expected 1 0", busy, in_ready); end
        wait_valid(lat, to);
        checks++; if (to || lat != c_LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, c_LAT); end
        checks++; if (product !== 16'h000F) begin errors++; $display("FAIL basic_product: got %h expected 000f", product); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL basic_return_idle: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy); end
        checks++; if (product !== 16'h000F) begin errors++; $display("FAIL basic_product_kept: got %h expected 000f", product); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_corners();
        logic [WIDTH-1:0]   va [6];
        logic [WIDTH-1:0]   vb [6];
        logic [2*WIDTH-1:0] exp_p [6];
        int lat;
        bit to;
        va[0] = 8'h80; vb[0] = 8'h80; exp_p[0] = 16'h4000;
        va[1] = 8'h80; vb[1] = 8'h01; exp_p[1] = 16'hFF80;
        va[2] = 8'h7F; vb[2] = 8'hFF; exp_p[2] = 16'hFF81;
        va[3] = 8'h00; vb[3] = 8'hFF; exp_p[3] = 16'h0000;
        va[4] = 8'h7F; vb[4] = 8'h80; exp_p[4] = 16'hC080;
        va[5] = 8'h00; vb[5] = 8'h00; exp_p[5] = 16'h0000;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_op(va[i], vb[i]);
            wait_valid(lat, to);
            checks++; if (to || lat != c_LAT)
                begin errors++; $display("FAIL corner_latency[%0d]: got %0d expected %0d", i, lat, c_LAT); end
            checks++; if (product !== exp_p[i])
                begin errors++; $display("FAIL corner_product[%0d] a=%h b=%h: got %h expected %h", i, va[i], vb[i], product, exp_p[i]); end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        int lat;
        bit to;
        out_ready = 1'b0;
        drive_op(8'hF9, 8'd6);   // -7 * 6
        wait_valid(lat, to);
        checks++; if (to || lat != c_LAT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, c_LAT); end
        for (int i = 0; i < 20; i++) begin
            checks++; if (product !== 16'hFFD6 || out_valid !== 1'b1 || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d]: got p=%h ov=%b ir=%b expected ffd6 1 0", i, product, out_valid, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready); end
        checks++; if (product !== 16'hFFD6) begin errors++; $display("FAIL bp_product_kept: got %h expected ffd6", product); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_ignore_in_calc();
        int lat;
        bit to;
        out_ready = 1'b1;
        drive_op(8'd10, 8'hFD);  // 10 * -3
        tick(); tick();
        a = 8'd100; b = 8'd100; in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        wait_valid(lat, to);
        checks++; if (to || lat != c_LAT - 4)
            begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat + 4, c_LAT); end
        checks++; if (product !== 16'hFFE2) begin errors++; $display("FAIL ignore_product: got %h expected ffe2", product); end
        tick();
        for (int i = 0; i < 12; i++) begin
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL ignore_no_extra_op[%0d]: got ov=%b busy=%b expected 0 0", i, out_valid, busy); end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_op();
        int lat;
        bit to;
        out_ready = 1'b1;
        drive_op(8'd3, 8'd4);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL midreset_ctrl: got ir=%b ov=%b busy=%b expected 1 0 0", in_ready, out_valid, busy); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (out_valid !== 1'b0)
                begin errors++; $display("FAIL midreset_no_output[%0d]: got %b expected 0", i, out_valid); end
            tick();
        end
        drive_op(8'd2, 8'd2);
        wait_valid(lat, to);
        checks++; if (to || lat != c_LAT) begin errors++; $display("FAIL midreset_followup_latency: got %0d expected %0d", lat, c_LAT); end
        checks++; if (product !== 16'h0004) begin errors++; $display("FAIL midreset_followup_product: got %h expected 0004", product); end
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back_random();
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        int lat;
        bit to;
        int stall;
        for (int n = 0; n < 1000; n++) begin
            x = $urandom();
            y = $urandom();
            checks++; if (in_ready !== 1'b1)
                begin errors++; $display("FAIL rand_in_ready[%0d]: got %b expected 1", n, in_ready); end
            stall     = $urandom_range(0, 3);
            out_ready = (stall == 0);
            drive_op(x, y);
            wait_valid(lat, to);
            checks++; if (to || lat != c_LAT)
                begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, c_LAT); end
            checks++; if (product !== ref_mul(x, y))
                begin errors++; $display("FAIL rand_product[%0d] a=%h b=%h: got %h expected %h", n, x, y, product, ref_mul(x, y)); end
            for (int s = 0; s < stall; s++) tick();
            out_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        tick();
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_ignore_in_calc();
        test_reset_mid_op();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
